tc_clk_switch_ctrl: RTL and testbench

Sequencer that owns the select of one glitch-sensitive clock mux plus the enable of the downstream clock gate. It accepts clock-source switch requests over a valid/ready handshake. Each switch runs gate-off -> drain -> flip select -> settle -> gate-on. When the clocked domain reports idle for long enough, it auto-gates that domain and reopens the gate on wake. It sits in the clock/reset control unit beside the clock cells it drives and runs entirely on one always-on reference clock.

---
 rtl/tc_clk_switch_ctrl.sv | 145 ++++++++++++++
 tb/tb_tc_clk_switch_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/tc_clk_switch_ctrl.sv
// Clock-source switch sequencer: owns the glitch-sensitive mux select and the
// downstream gate enable, and auto-gates the domain when it stays idle.
module tc_clk_switch_ctrl #(
  parameter int unsigned DrainCycles  = 4,
  parameter int unsigned SettleCycles = 8,
  parameter int unsigned IdleCycles   = 16,
  parameter int unsigned CntWidth     = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sel_valid_i,
  input  logic sel_target_i,
  output logic sel_ready_o,
  output logic done_o,
  input  logic busy_i,
  input  logic wake_i,
  output logic clk_sel_o,
  output logic clk_en_o,
  output logic gated_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_GATED  = 2'd3
  } state_e;

  // Terminal counts: a phase ends on the edge where the counter holds N-1.
  localparam logic [CntWidth-1:0] DrainLast  = CntWidth'(DrainCycles - 1);
  localparam logic [CntWidth-1:0] SettleLast = CntWidth'(SettleCycles - 1);
  localparam logic [CntWidth-1:0] IdleLast   =
    CntWidth'((IdleCycles == 0) ? 0 : IdleCycles - 1);
  localparam bit AutoGateEn = (IdleCycles != 0);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                sel_q, sel_d;
  logic                en_q, en_d;
  logic                done_q, done_d;
  logic                gated_q, gated_d;
  logic                tgt_q, tgt_d;

  logic hs, hs_same, hs_diff;

  assign sel_ready_o = (state_q == ST_RUN) | (state_q == ST_GATED);
  assign hs          = sel_valid_i & sel_ready_o;
  assign hs_same     = hs & (sel_target_i == sel_q);
  assign hs_diff     = hs & (sel_target_i != sel_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    done_d  = 1'b0;
    gated_d = gated_q;
    tgt_d   = tgt_q;

    if (hs_same) begin
      // Already on the requested source: acknowledge, keep RUN/GATED as is.
      done_d = 1'b1;
      cnt_d  = '0;
    end else if (hs_diff) begin
      // Close the gate first so the mux never flips under a live clock.
      tgt_d   = sel_target_i;
      en_d    = 1'b0;
      gated_d = 1'b0;
      state_d = ST_DRAIN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (busy_i || !AutoGateEn) begin
            cnt_d = '0;
          end else if (cnt_q == IdleLast) begin
            en_d    = 1'b0;
            gated_d = 1'b1;
            state_d = ST_GATED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
        ST_GATED: begin
          if (wake_i || busy_i) begin
            en_d    = 1'b1;
            gated_d = 1'b0;
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == DrainLast) begin
            sel_d   = tgt_q;
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SettleLast) begin
            en_d    = 1'b1;
            done_d  = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      en_q    <= 1'b1;
      done_q  <= 1'b0;
      gated_q <= 1'b0;
      tgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      done_q  <= done_d;
      gated_q <= gated_d;
      tgt_q   <= tgt_d;
    end
  end

  assign clk_sel_o = sel_q;
  assign clk_en_o  = en_q;
  assign done_o    = done_q;
  assign gated_o   = gated_q;

endmodule

// File: tb/tb_tc_clk_switch_ctrl.sv
// Bench for tc_clk_switch_ctrl at default parameters: vector table for the
// switch handshakes plus hand sequences for idle gating, wake and reset.
module tb_tc_clk_switch_ctrl;

  logic clk_i = 1'b0;
  logic rst_i, sel_valid_i, sel_target_i, busy_i, wake_i;
  logic sel_ready_o, done_o, clk_sel_o, clk_en_o, gated_o;

  always #5 clk_i = ~clk_i;

  tc_clk_switch_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sel_valid_i (sel_valid_i),
    .sel_target_i(sel_target_i),
    .sel_ready_o (sel_ready_o),
    .done_o      (done_o),
    .busy_i      (busy_i),
    .wake_i      (wake_i),
    .clk_sel_o   (clk_sel_o),
    .clk_en_o    (clk_en_o),
    .gated_o     (gated_o)
  );

  // Expected output word: {ready, done, sel, en, gated}
  localparam logic [4:0] E_RUN0   = 5'b10010;
  localparam logic [4:0] E_RUN1   = 5'b10110;
  localparam logic [4:0] E_DONE0  = 5'b11010;
  localparam logic [4:0] E_DONE1  = 5'b11110;
  localparam logic [4:0] E_SW0    = 5'b00000;
  localparam logic [4:0] E_SW1    = 5'b00100;
  localparam logic [4:0] E_GATED0 = 5'b10001;
  localparam logic [4:0] E_GDONE0 = 5'b11001;

  typedef struct {
    logic       v;
    logic       t;
    logic       b;
    logic       w;
    logic [4:0] e;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic void add(input logic v, t, b, w, input logic [4:0] e);
    vec_t x;
    x.v = v; x.t = t; x.b = b; x.w = w; x.e = e;
    tbl.push_back(x);
  endfunction

  // Drive one cycle's inputs, queue the expectation, check at the next negedge.
  task automatic cyc(input string nm, input logic v, t, b, w, r, input logic [4:0] e);
    logic [4:0] got, want;
    sel_valid_i  = v;
    sel_target_i = t;
    busy_i       = b;
    wake_i       = w;
    rst_i        = r;
    exp_q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
    want = exp_q.pop_front();
    got  = {sel_ready_o, done_o, clk_sel_o, clk_en_o, gated_o};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b (ready,done,sel,en,gated) at %0t", nm, got, want, $time);
    end
  endtask

  initial begin
    // Switch 0->1 with a stray request held during the switch, then same-target.
    add(1, 1, 1, 0, E_SW0);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, E_SW0);
    add(1, 0, 1, 0, E_SW1);
    for (int i = 0; i < 7; i++) add(1, 0, 1, 0, E_SW1);
    add(0, 0, 1, 0, E_DONE1);
    add(0, 0, 1, 0, E_RUN1);
    add(1, 1, 1, 0, E_DONE1);
    add(0, 0, 1, 0, E_RUN1);
    // Switch back 1->0, then same-target request on clk0.
    add(1, 0, 1, 0, E_SW1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, E_SW1);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, E_SW0);
    add(0, 0, 1, 0, E_DONE0);
    add(1, 0, 1, 0, E_DONE0);
    add(0, 0, 1, 0, E_RUN0);

    sel_valid_i = 0; sel_target_i = 0; busy_i = 1; wake_i = 0; rst_i = 1;
    cyc("reset", 0, 0, 1, 0, 1, E_RUN0);
    for (int i = 0; i < 20; i++) cyc("busy_run", 0, 0, 1, 0, 0, E_RUN0);

    foreach (tbl[i]) cyc($sformatf("vec%0d", i), tbl[i].v, tbl[i].t, tbl[i].b, tbl[i].w, 1'b0, tbl[i].e);

    // Idle gating on the 16th idle edge, then wake.
    for (int i = 0; i < 15; i++) cyc("idle_count", 0, 0, 0, 0, 0, E_RUN0);
    cyc("auto_gate", 0, 0, 0, 0, 0, E_GATED0);
    for (int i = 0; i < 2; i++) cyc("stay_gated", 0, 0, 0, 0, 0, E_GATED0);
    cyc("wake", 0, 0, 0, 1, 0, E_RUN0);
    cyc("busy_after_wake", 0, 0, 1, 0, 0, E_RUN0);

    // Busy pulse restarts the idle window.
    for (int i = 0; i < 10; i++) cyc("idle_pre_pulse", 0, 0, 0, 0, 0, E_RUN0);
    cyc("busy_pulse", 0, 0, 1, 0, 0, E_RUN0);
    for (int i = 0; i < 15; i++) cyc("idle_post_pulse", 0, 0, 0, 0, 0, E_RUN0);
    cyc("gate_after_pulse", 0, 0, 0, 0, 0, E_GATED0);

    // From GATED: same target keeps gating; different target + wake switches.
    cyc("gated_same", 1, 0, 0, 1, 0, E_GDONE0);
    cyc("gated_switch", 1, 1, 0, 1, 0, E_SW0);
    for (int i = 0; i < 3; i++) cyc("gsw_drain", 0, 0, 0, 0, 0, E_SW0);
    cyc("gsw_flip", 0, 0, 0, 0, 0, E_SW1);
    for (int i = 0; i < 7; i++) cyc("gsw_settle", 0, 0, 0, 0, 0, E_SW1);
    cyc("gsw_done", 0, 0, 0, 0, 0, E_DONE1);
    cyc("gsw_run", 0, 0, 1, 0, 0, E_RUN1);

    // Reset mid-SETTLE, then a held request is accepted again.
    cyc("reset2", 0, 0, 1, 0, 1, E_RUN0);
    cyc("rs_accept", 1, 1, 1, 0, 0, E_SW0);
    for (int i = 0; i < 3; i++) cyc("rs_drain", 1, 1, 1, 0, 0, E_SW0);
    cyc("rs_flip", 1, 1, 1, 0, 0, E_SW1);
    for (int i = 0; i < 2; i++) cyc("rs_settle", 1, 1, 1, 0, 0, E_SW1);
    cyc("rs_reset", 1, 1, 1, 0, 1, E_RUN0);
    cyc("rs_reaccept", 1, 1, 1, 0, 0, E_SW0);
    for (int i = 0; i < 3; i++) cyc("rs2_drain", 0, 0, 1, 0, 0, E_SW0);
    cyc("rs2_flip", 0, 0, 1, 0, 0, E_SW1);
    for (int i = 0; i < 7; i++) cyc("rs2_settle", 0, 0, 1, 0, 0, E_SW1);
    cyc("rs2_done", 0, 0, 1, 0, 0, E_DONE1);
    cyc("rs2_run", 0, 0, 1, 0, 0, E_RUN1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
